// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a palette-indexed sprite from a synchronous ROM into the frame buffer.
// Optional horizontal mirroring is compiled in with BLIT_HFLIP_EN.
module sprite_blitter #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int SCR_W      = 640,
    parameter int SCR_H      = 480,
    parameter int IDX_W      = 3,
    parameter int FB_AW      = 19,
    parameter int TRANSP_IDX = 0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic signed [10:0]                spr_x,
    input  logic signed [10:0]                spr_y,
`ifdef BLIT_HFLIP_EN
    input  logic                              hflip,
`endif
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(SPR_W*SPR_H)-1:0]    rom_addr,
    input  logic [IDX_W-1:0]                  rom_q,
    output logic                              fb_we,
    output logic [FB_AW-1:0]                  fb_addr,
    output logic [IDX_W-1:0]                  fb_data,
    input  logic                              fb_ready
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam int AW = $clog2(SPR_W*SPR_H);
    localparam logic signed [11:0] SCR_W12 = 12'(SCR_W);
    localparam logic signed [11:0] SCR_H12 = 12'(SCR_H);
    localparam logic [FB_AW-1:0]   SCR_WA  = FB_AW'(SCR_W);
    localparam logic [IDX_W-1:0]   TRANSP  = IDX_W'(TRANSP_IDX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_FIN
    } state_t;

    state_t            state_q;
    logic signed [10:0] x_q, y_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic              on_q;
    logic              busy_q, done_q, fb_we_q;
    logic [AW-1:0]     rom_addr_q;
    logic [FB_AW-1:0]  fb_addr_q;
    logic [IDX_W-1:0]  fb_data_q;

    logic [CW-1:0]     col_d;
    logic [RW-1:0]     row_d;
    logic [AW-1:0]     rom_addr_d, rom_start;
    logic              last, on_d;
    logic signed [11:0] sx, sy;
    logic [FB_AW-1:0]  lin_d;

    assign last  = (col_q == CW'(SPR_W-1)) && (row_q == RW'(SPR_H-1));
    assign col_d = col_q + CW'(1);
    assign row_d = (col_q == CW'(SPR_W-1)) ? row_q + RW'(1) : row_q;

`ifdef BLIT_HFLIP_EN
    logic flip_q;
    // Mirroring only changes which ROM column is fetched, never the screen column.
    assign rom_addr_d = {row_d, flip_q ? ~col_d : col_d};
    assign rom_start  = {RW'(0), hflip ? ~CW'(0) : CW'(0)};
`else
    assign rom_addr_d = {row_d, col_d};
    assign rom_start  = '0;
`endif

    assign sx = {x_q[10], x_q} + {{(12-CW){1'b0}}, col_q};
    assign sy = {y_q[10], y_q} + {{(12-RW){1'b0}}, row_q};
    assign on_d = !sx[11] && (sx < SCR_W12) && !sy[11] && (sy < SCR_H12);
    assign lin_d = FB_AW'(unsigned'(sy)) * SCR_WA + FB_AW'(unsigned'(sx));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            on_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fb_we_q    <= 1'b0;
            rom_addr_q <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
`ifdef BLIT_HFLIP_EN
            flip_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q        <= spr_x;
                        y_q        <= spr_y;
                        col_q      <= '0;
                        row_q      <= '0;
                        rom_addr_q <= rom_start;
`ifdef BLIT_HFLIP_EN
                        flip_q     <= hflip;
`endif
                        busy_q     <= 1'b1;
                        state_q    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    on_q <= on_d;
                    // Address only updated for visible pixels so it never leaves the buffer.
                    if (on_d) fb_addr_q <= lin_d;
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (on_q && (rom_q != TRANSP)) begin
                        fb_data_q <= rom_q;
                        fb_we_q   <= 1'b1;
                        state_q   <= S_WRITE;
                    end else if (last) begin
                        state_q <= S_FIN;
                    end else begin
                        col_q      <= col_d;
                        row_q      <= row_d;
                        rom_addr_q <= rom_addr_d;
                        state_q    <= S_ADDR;
                    end
                end
                S_WRITE: begin
                    if (fb_ready) begin
                        fb_we_q <= 1'b0;
                        if (last) begin
                            state_q <= S_FIN;
                        end else begin
                            col_q      <= col_d;
                            row_q      <= row_d;
                            rom_addr_q <= rom_addr_d;
                            state_q    <= S_ADDR;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign fb_we    = fb_we_q;
    assign rom_addr = rom_addr_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: directed and randomized blits against a pixel-loop reference.
// Mirroring test runs only when BLIT_HFLIP_EN is defined.
module tb_sprite_blitter;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic signed [10:0] spr_x, spr_y;
    logic               busy, done, fb_we, fb_ready;
    logic [9:0]         rom_addr;
    logic [2:0]         rom_q;
    logic [18:0]        fb_addr;
    logic [2:0]         fb_data;
`ifdef BLIT_HFLIP_EN
    logic               hflip = 1'b0;
`endif

    sprite_blitter dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .spr_x    (spr_x),
        .spr_y    (spr_y),
`ifdef BLIT_HFLIP_EN
        .hflip    (hflip),
`endif
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_ready (fb_ready)
    );

    always #5 clock = ~clock;

    logic [2:0] rom [1024];
    always @(posedge clock) rom_q <= rom[rom_addr];

    int n_pass = 0;
    int n_total = 0;
    int exp_a[$], exp_d[$], got_a[$], got_d[$];
    int cyc;
    bit stable;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: walk every sprite pixel, keep visible opaque ones in row-major order.
    task automatic build_exp(input int x, input int y, input bit flip);
        exp_a.delete();
        exp_d.delete();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                int px, py, v;
                px = x + c;
                py = y + r;
                v  = rom[r*32 + (flip ? 31 - c : c)];
                if (px >= 0 && px < 640 && py >= 0 && py < 480 && v != 0) begin
                    exp_a.push_back(py*640 + px);
                    exp_d.push_back(v);
                end
            end
    endtask

    task automatic compare(input string tag);
        int nbad = 0;
        bit first = 1'b1;
        chk({tag, "_nwrites"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
            if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) begin
                nbad++;
                if (first) begin
                    first = 1'b0;
                    chk({tag, "_bad_addr"}, got_a[i], exp_a[i]);
                    chk({tag, "_bad_data"}, got_d[i], exp_d[i]);
                end
            end
        chk({tag, "_mismatches"}, nbad, 0);
    endtask

    // mode 0: ready=1, 1: random ready, 2: stall first write 7 cycles
    task automatic run_blit(input int x, input int y, input int mode,
                            input bit inject, input int abort_at);
        int stall = 7;
        bit seen_we = 1'b0;
        logic [18:0] hold;
        hold = '0;
        got_a.delete();
        got_d.delete();
        stable = 1'b1;
        @(negedge clock);
        spr_x = 11'(x);
        spr_y = 11'(y);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20000) begin
            if (abort_at >= 0 && got_a.size() == abort_at) break;
            if (fb_we && !seen_we) begin
                seen_we = 1'b1;
                hold = fb_addr;
            end
            case (mode)
                1: fb_ready = ($urandom_range(0, 3) != 0);
                2: if (fb_we && stall > 0) begin
                       fb_ready = 1'b0;
                       stall--;
                       if (fb_addr !== hold) stable = 1'b0;
                   end else fb_ready = 1'b1;
                default: fb_ready = 1'b1;
            endcase
            if (fb_we && fb_ready) begin
                got_a.push_back(int'(fb_addr));
                got_d.push_back(int'(fb_data));
            end
            if (inject && cyc == 100) begin
                start = 1'b1;
                spr_x = 11'sd300;
                spr_y = 11'sd200;
            end else start = 1'b0;
            @(negedge clock);
            cyc++;
        end
        fb_ready = 1'b1;
    endtask

    task automatic after_done(input string tag);
        chk({tag, "_done"}, done, 1'b1);
        @(negedge clock);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_low"}, busy, 1'b0);
    endtask

    initial begin
        int oob, zeros, dn, we;
        reset = 1'b1;
        start = 1'b0;
        spr_x = '0;
        spr_y = '0;
        fb_ready = 1'b1;
        for (int i = 0; i < 1024; i++) rom[i] = 3'd5;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", fb_we, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);

        // 1: opaque on-screen sprite
        build_exp(100, 50, 1'b0);
        run_blit(100, 50, 0, 1'b0, -1);
        chk("t1_cycles", cyc, 3073);
        chk("t1_first", got_a[0], 32100);
        chk("t1_last", got_a[got_a.size()-1], 51971);
        compare("t1");
        after_done("t1");

        // 2: checkerboard transparency
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) rom[r*32+c] = ((r + c) % 2 != 0) ? 3'd5 : 3'd0;
        build_exp(0, 0, 1'b0);
        run_blit(0, 0, 0, 1'b0, -1);
        zeros = 0;
        foreach (got_d[i]) if (got_d[i] == 0) zeros++;
        chk("t2_count", got_a.size(), 512);
        chk("t2_zero_writes", zeros, 0);
        compare("t2");
        after_done("t2");

        // 3: clipped at left and bottom
        for (int i = 0; i < 1024; i++) rom[i] = 3'd1;
        build_exp(-10, 470, 1'b0);
        run_blit(-10, 470, 0, 1'b0, -1);
        oob = 0;
        foreach (got_a[i]) if (got_a[i] >= 307200) oob++;
        chk("t3_count", got_a.size(), 220);
        chk("t3_oob", oob, 0);
        compare("t3");
        after_done("t3");

        // 4: first write stalled 7 cycles
        for (int i = 0; i < 1024; i++) rom[i] = 3'd5;
        build_exp(100, 50, 1'b0);
        run_blit(100, 50, 2, 1'b0, -1);
        chk("t4_cycles", cyc, 3080);
        chk("t4_stable", stable, 1'b1);
        compare("t4");
        after_done("t4");

        // 5: start while busy is ignored, then abort mid-blit
        run_blit(100, 50, 0, 1'b1, -1);
        compare("t5_inject");
        after_done("t5");
        run_blit(100, 50, 0, 1'b0, 300);
        chk("t5_abort_count", got_a.size(), 300);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t5_abort_we", fb_we, 0);
        chk("t5_abort_busy", busy, 0);
        dn = 0;
        we = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dn++;
            if (fb_we) we++;
        end
        chk("t5_abort_no_done", dn, 0);
        chk("t5_abort_no_we", we, 0);

        // randomized positions, contents and back-pressure
        for (int k = 0; k < 4; k++) begin
            int rx, ry;
            rx = int'($urandom_range(0, 760)) - 60;
            ry = int'($urandom_range(0, 560)) - 60;
            for (int i = 0; i < 1024; i++) rom[i] = 3'($urandom_range(0, 7));
            build_exp(rx, ry, 1'b0);
            run_blit(rx, ry, 1, 1'b0, -1);
            compare("rand");
            after_done("rand");
        end

`ifdef BLIT_HFLIP_EN
        // 6: mirrored fetch puts ROM column 0 at screen column 31
        for (int i = 0; i < 1024; i++) rom[i] = (i % 32 == 0) ? 3'd5 : 3'd0;
        hflip = 1'b1;
        build_exp(0, 0, 1'b1);
        run_blit(0, 0, 0, 1'b0, -1);
        hflip = 1'b0;
        chk("t6_count", got_a.size(), 32);
        chk("t6_first", got_a[0], 31);
        compare("t6");
        after_done("t6");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
